// File: rtl/mont_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier.
// Holds the FSM state type, the default operand width and the counter-width helper.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } mont_state_e;

  localparam int MONT_N_DEFAULT = 512;

  function automatic int mont_cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mont_addsub.sv
// Combinational W-bit adder/subtractor used for the t, u and d datapath terms.
// Kept as its own block so a pipelined or carry-save version can replace it later.
module mont_addsub #(
  parameter int W = 514
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         borrow
);

  assign sum    = sub ? (x - y) : (x + y);
  // operands stay below 2^(W-1), so the top bit of the difference is the borrow
  assign borrow = sub & sum[W-1];

endmodule

// File: rtl/montgomery_stream.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-N mod m, one iteration per clock,
// valid/ready on both sides, error flag for an even modulus.
module montgomery_stream
  import mont_pkg::*;
#(
  parameter int N = MONT_N_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         error,
  output logic         busy
);

  localparam int CNT_W = mont_cnt_w(N);

  mont_state_e      state_r;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic [N-1:0]     m_r;
  logic [N:0]       c_r;
  logic [CNT_W-1:0] i_r;

  logic [N+1:0] t_x_s, t_y_s, t_sum_s;
  logic [N+1:0] u_y_s, u_sum_s;
  logic [N+1:0] d_x_s, d_y_s, d_sum_s;
  logic [N:0]   u_half_s;
  logic [N:0]   d_low_s;
  logic         d_borrow_s;
  logic         unused_t_borrow_s;
  logic         unused_u_borrow_s;

  assign t_x_s    = {1'b0, c_r};
  assign t_y_s    = a_r[i_r] ? {2'b00, b_r} : {(N+2){1'b0}};
  assign u_y_s    = t_sum_s[0] ? {2'b00, m_r} : {(N+2){1'b0}};
  assign u_half_s = (N+1)'(u_sum_s >> 1);
  assign d_x_s    = {1'b0, c_r};
  assign d_y_s    = {2'b00, m_r};
  assign d_low_s  = (N+1)'(d_sum_s);

  mont_addsub #(.W(N+2)) u_t_add (
    .x(t_x_s), .y(t_y_s), .sub(1'b0), .sum(t_sum_s), .borrow(unused_t_borrow_s)
  );

  mont_addsub #(.W(N+2)) u_u_add (
    .x(t_sum_s), .y(u_y_s), .sub(1'b0), .sum(u_sum_s), .borrow(unused_u_borrow_s)
  );

  mont_addsub #(.W(N+2)) u_d_sub (
    .x(d_x_s), .y(d_y_s), .sub(1'b1), .sum(d_sum_s), .borrow(d_borrow_s)
  );

  // FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      m_r       <= {N{1'b0}};
      c_r       <= {(N+1){1'b0}};
      i_r       <= {CNT_W{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= {N{1'b0}};
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            m_r      <= in_m;
            c_r      <= {(N+1){1'b0}};
            i_r      <= {CNT_W{1'b0}};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (!in_m[0]) begin
              // out_valid follows one cycle later, from DONE
              state_r <= DONE;
              error   <= 1'b1;
              result  <= {N{1'b0}};
            end else begin
              state_r <= CALC;
              error   <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          c_r <= u_half_s;
          i_r <= i_r + CNT_W'(1);
          if (i_r == CNT_W'(N - 1)) begin
            state_r <= REDUCE;
          end else begin
            state_r <= CALC;
          end
        end
        REDUCE: begin
          if (!d_borrow_s) begin
            c_r    <= d_low_s;
            result <= d_low_s[N-1:0];
          end else begin
            result <= c_r[N-1:0];
          end
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_stream.sv
// Self-checking bench for montgomery_stream at N=8 and N=512, against a
// modular-halving reference model with hand-computed anchor values.
module tb_montgomery_stream;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_error, s_busy;
  logic [7:0] s_a, s_b, s_m, s_result;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_error, w_busy;
  logic [511:0] w_a, w_b, w_m, w_result;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]   exp8_r;
  logic         exp8_e;
  logic         pend8 = 1'b0;
  logic [511:0] exp512_r;
  logic         exp512_e;
  logic         pend512 = 1'b0;

  montgomery_stream #(.N(8)) dut8 (
    .clk(clk), .resetn(resetn),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_a), .in_b(s_b), .in_m(s_m),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .error(s_error), .busy(s_busy)
  );

  montgomery_stream #(.N(512)) dut512 (
    .clk(clk), .resetn(resetn),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_a), .in_b(w_b), .in_m(w_m),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .error(w_error), .busy(w_busy)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // a*b*2^-n mod m: reduce the full product, then halve n times modulo m
  function automatic logic [1039:0] mont_ref(input logic [1039:0] a, input logic [1039:0] b,
                                             input logic [1039:0] m, input int n);
    logic [1039:0] r;
    r = (a * b) % m;
    for (int k = 0; k < n; k++) r = r[0] ? ((r + m) >> 1) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    if (!m[0]) return 8'd0;
    return 8'(mont_ref(1040'(a), 1040'(b), 1040'(m), 8));
  endfunction

  function automatic logic [511:0] model512(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m);
    if (!m[0]) return 512'd0;
    return 512'(mont_ref(1040'(a), 1040'(b), 1040'(m), 512));
  endfunction

  // compare process: whenever a result is presented it must match the model
  always @(negedge clk) begin
    if (resetn) begin
      if (s_out_valid) begin
        chk("valid8_has_op", 512'(pend8), 512'd1);
        chk("result8", 512'(s_result), 512'(exp8_r));
        chk("error8", 512'(s_error), 512'(exp8_e));
        chk("in_ready8_in_done", 512'(s_in_ready), 512'd0);
        chk("busy8_in_done", 512'(s_busy), 512'd1);
      end
      if (w_out_valid) begin
        chk("valid512_has_op", 512'(pend512), 512'd1);
        chk("result512", w_result, exp512_r);
        chk("error512", 512'(w_error), 512'(exp512_e));
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!s_in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready8_before", 512'(s_in_ready), 512'd1);
    s_in_valid = 1'b1; s_a = a; s_b = b; s_m = m;
    exp8_r = model8(a, b, m); exp8_e = ~m[0]; pend8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0; s_a = ~a; s_b = ~b; s_m = ~m;
    lat = 0;
    while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency8", 512'(lat), m[0] ? 512'd9 : 512'd1);
    repeat (hold) @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_out_ready = 1'b0; pend8 = 1'b0;
    chk("in_ready8_after", 512'(s_in_ready), 512'd1);
    chk("valid8_cleared", 512'(s_out_valid), 512'd0);
  endtask

  task automatic op512(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
    int lat;
    w_in_valid = 1'b1; w_a = a; w_b = b; w_m = m;
    exp512_r = model512(a, b, m); exp512_e = ~m[0]; pend512 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0; w_a = ~a;
    lat = 0;
    while (!w_out_valid && lat < 600) begin @(negedge clk); lat++; end
    chk("latency512", 512'(lat), 512'd513);
    w_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_out_ready = 1'b0; pend512 = 1'b0;
    chk("in_ready512_after", 512'(w_in_ready), 512'd1);
  endtask

  initial begin
    logic [511:0] ra, rb, rm;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = 8'd0; s_b = 8'd0; s_m = 8'd0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = 512'd0; w_b = 512'd0; w_m = 512'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 512'(s_in_ready), 512'd1);
    chk("rst_out_valid", 512'(s_out_valid), 512'd0);
    chk("rst_result", 512'(s_result), 512'd0);
    chk("rst_error", 512'(s_error), 512'd0);
    chk("rst_busy", 512'(s_busy), 512'd0);
    resetn = 1'b1;

    chk("model_5x7_m13", 512'(model8(8'd5, 8'd7, 8'd13)), 512'd1);
    chk("model_1x1_m13", 512'(model8(8'd1, 8'd1, 8'd13)), 512'd3);
    chk("model_0x12_m13", 512'(model8(8'd0, 8'd12, 8'd13)), 512'd0);
    chk("model_200x100_m255", 512'(model8(8'd200, 8'd100, 8'd255)), 512'd110);
    chk("model512_ones", model512(512'd1, 512'd1, {512{1'b1}}), 512'd1);

    @(negedge clk);
    op8(8'd5, 8'd7, 8'd13, 0);
    op8(8'd1, 8'd1, 8'd13, 0);
    op8(8'd0, 8'd12, 8'd13, 0);
    op8(8'd12, 8'd12, 8'd13, 0);
    op8(8'd200, 8'd100, 8'd255, 0);
    op8(8'd3, 8'd5, 8'd12, 0);
    op8(8'd12, 8'd11, 8'd13, 20);
    op8(8'd2, 8'd3, 8'd13, 0);
    op8(8'd0, 8'd0, 8'd1, 0);
    op8(8'd254, 8'd253, 8'd255, 0);

    // abort in CALC at i=4; no result may ever appear for it
    s_in_valid = 1'b1; s_a = 8'd5; s_b = 8'd7; s_m = 8'd13;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", 512'(s_busy), 512'd1);
    resetn = 1'b0;
    #1;
    chk("abort_in_ready", 512'(s_in_ready), 512'd1);
    chk("abort_out_valid", 512'(s_out_valid), 512'd0);
    chk("abort_result", 512'(s_result), 512'd0);
    chk("abort_error", 512'(s_error), 512'd0);
    chk("abort_busy", 512'(s_busy), 512'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_valid_after_abort", 512'(s_out_valid), 512'd0);
    op8(8'd5, 8'd7, 8'd13, 0);

    op512(512'd1, 512'd1, {512{1'b1}});
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 16; k++) begin
        rm[32*k +: 32] = $urandom;
        ra[32*k +: 32] = $urandom;
        rb[32*k +: 32] = $urandom;
      end
      rm[0] = 1'b1;
      op512(ra % rm, rb % rm, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
